// File: rtl/load_store_unit.sv
// Load/store unit: aligned byte/half/word access to a word-wide memory with sub-word read-modify-write.
// Latency (accept -> rsp): error 1, load 2, word store 2, sub-word store 3; req_ready only in IDLE, one access in flight.
module load_store_unit #(
    parameter int MEM_WORDS = 4500
) (
    input  logic        C,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_Din,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_Ra,
    output logic [31:0] mem_Wa,
    input  logic [31:0] mem_Dout
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_next;
    logic        accept;
    logic        req_err;
    logic [31:0] req_word;

    logic        q_we, q_uns, q_err;
    logic [1:0]  q_size;
    logic [31:0] q_addr, q_wdata, q_rd;
    logic [31:0] q_word;
    logic [31:0] store_word, load_word;

    assign accept   = req_valid && req_ready;
    assign req_word = {2'b00, req_addr[31:2]};
    assign q_word   = {2'b00, q_addr[31:2]};

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
            SZ_BYTE: req_err = 1'b0;
            default: req_err = 1'b1;
        endcase
        if (req_word >= MEM_LIMIT) req_err = 1'b1;
    end

    always_ff @(posedge C) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                                state_next = RESP;
                    else if (req_we && req_size == SZ_WORD)     state_next = WRITE;
                    else                                        state_next = READ;
                end
            end
            READ:    state_next = q_we ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge C) begin
        if (rst) begin
            q_we    <= 1'b0;
            q_uns   <= 1'b0;
            q_err   <= 1'b0;
            q_size  <= 2'b00;
            q_addr  <= '0;
            q_wdata <= '0;
            q_rd    <= '0;
        end else begin
            if (accept) begin
                q_we    <= req_we;
                q_uns   <= req_unsigned;
                q_err   <= req_err;
                q_size  <= req_size;
                q_addr  <= req_addr;
                q_wdata <= req_wdata;
            end
            if (state == READ) q_rd <= mem_Dout;
        end
    end

    // Sub-word stores replace only the addressed lane of the word fetched in READ.
    always_comb begin
        store_word = q_rd;
        case (q_size)
            SZ_BYTE: begin
                case (q_addr[1:0])
                    2'd0:    store_word[7:0]   = q_wdata[7:0];
                    2'd1:    store_word[15:8]  = q_wdata[7:0];
                    2'd2:    store_word[23:16] = q_wdata[7:0];
                    default: store_word[31:24] = q_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (q_addr[1]) store_word[31:16] = q_wdata[15:0];
                else           store_word[15:0]  = q_wdata[15:0];
            end
            default: store_word = q_wdata;
        endcase
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        case (q_addr[1:0])
            2'd0:    b = q_rd[7:0];
            2'd1:    b = q_rd[15:8];
            2'd2:    b = q_rd[23:16];
            default: b = q_rd[31:24];
        endcase
        h = q_addr[1] ? q_rd[31:16] : q_rd[15:0];
        case (q_size)
            SZ_BYTE: load_word = {{24{b[7] & ~q_uns}}, b};
            SZ_HALF: load_word = {{16{h[15] & ~q_uns}}, h};
            default: load_word = q_rd;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_Ra    = '0;
        mem_Wa    = '0;
        mem_Din   = '0;
        case (state)
            IDLE: req_ready = 1'b1;
            READ: begin
                mem_re = 1'b1;
                mem_Ra = q_word;
            end
            WRITE: begin
                mem_we  = 1'b1;
                mem_Wa  = q_word;
                mem_Din = store_word;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = q_err;
                rsp_rdata = (q_err || q_we) ? 32'd0 : load_word;
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule
